// File: rtl/gray_conv_arbiter_if.sv
// Requester and downstream bundle for gray_conv_arbiter.
// master drives requests/out_ready; slave is the arbiter.
interface gray_conv_arbiter_if #(
   parameter int SIZE = 4,
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SIZE-1:0] req_gray;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic [SIZE-1:0]      out_bin;
   logic [ID_W-1:0]      out_id;
   logic                 out_ready;

   modport master (
      output req_valid,
      output req_gray,
      input  req_ready,
      input  out_valid,
      input  out_bin,
      input  out_id,
      output out_ready
   );

   modport slave (
      input  req_valid,
      input  req_gray,
      output req_ready,
      output out_valid,
      output out_bin,
      output out_id,
      input  out_ready
   );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter, 1-entry output stage.
// Define GRAY_CONV_ARB_STATS_EN to add the 16-bit conv_count port.
module gray_conv_arbiter #(
   parameter int SIZE = 4,
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic          clk,
   input  logic          rst,
`ifdef GRAY_CONV_ARB_STATS_EN
   output logic [15:0]   conv_count,
`endif
   gray_conv_arbiter_if.slave bus
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SIZE-1:0] bin_q, bin_d;
   logic [ID_W-1:0] id_q, id_d;

   logic            load;
   logic            any_req;
   logic            xfer;
   logic [ID_W-1:0] grant;
   logic [SIZE-1:0] gray_sel;
   logic [SIZE-1:0] bin_sel;

   function automatic logic [SIZE-1:0] gray2bin(
      input logic [SIZE-1:0] g
   );
      logic [SIZE-1:0] b;
      b[SIZE-1] = g[SIZE-1];
      for (int i = SIZE - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign load    = (state_q == S_EMPTY) || bus.out_ready;
   assign any_req = |bus.req_valid;
   assign xfer    = load && any_req;

   // Search req_valid from rr_ptr upward, wrapping at NREQ-1.
   always_comb begin
      int idx;
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   assign gray_sel = bus.req_gray[int'(grant)*SIZE +: SIZE];
   assign bin_sel  = gray2bin(gray_sel);

   // One-hot accept for the winner, only when the stage can load.
   always_comb begin
      bus.req_ready = '0;
      if (xfer) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   // Next-state for FSM, pointer and output register.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      bin_d    = bin_q;
      id_d     = id_q;
      if (xfer) begin
         state_d = S_FULL;
         bin_d   = bin_sel;
         id_d    = grant;
         if (int'(grant) == NREQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant + ID_W'(1);
         end
      end else if (state_q == S_FULL && bus.out_ready) begin
         state_d = S_EMPTY;
      end
   end

   // Register state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         rr_ptr_q <= '0;
         bin_q    <= '0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         bin_q    <= bin_d;
         id_q     <= id_d;
      end
   end

   assign bus.out_valid = (state_q == S_FULL);
   assign bus.out_bin   = bin_q;
   assign bus.out_id    = id_q;

`ifdef GRAY_CONV_ARB_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   assign cnt_d = (bus.out_valid && bus.out_ready) ? cnt_q + 16'd1 : cnt_q;

   // Count completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conv_count = cnt_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter.
// Expected values are hand-derived Gray-to-binary results.
module tb_gray_conv_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   gray_conv_arbiter_if #(.SIZE(4), .NREQ(4), .ID_W(2)) bus ();

`ifdef GRAY_CONV_ARB_STATS_EN
   logic [15:0] conv_count;
`endif

   gray_conv_arbiter #(.SIZE(4), .NREQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef GRAY_CONV_ARB_STATS_EN
      .conv_count (conv_count),
`endif
      .bus        (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lane(input int k, input logic [3:0] g);
      bus.req_gray[k*4 +: 4] = g;
   endtask

   logic [31:0] rr_bin [4];

   initial begin
      bus.req_valid = '0;
      bus.req_gray  = '0;
      bus.out_ready = 1'b0;
      rr_bin[0] = 'd0;
      rr_bin[1] = 'd2;
      rr_bin[2] = 'd6;
      rr_bin[3] = 'd8;

      // reset state
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.out_valid), 'd0);
      chk("rst_bin", 32'(bus.out_bin), 'd0);
      chk("rst_id", 32'(bus.out_id), 'd0);
      chk("idle_ready", 32'(bus.req_ready), 'b0000);

      // single requester 2, Gray 0110 -> 0100
      bus.out_ready = 1'b1;
      bus.req_valid = 4'b0100;
      lane(2, 4'b0110);
      #1;
      chk("single_ready", 32'(bus.req_ready), 'b0100);
      step();
      chk("single_valid", 32'(bus.out_valid), 'd1);
      chk("single_bin", 32'(bus.out_bin), 'b0100);
      chk("single_id", 32'(bus.out_id), 'd2);
      bus.req_valid = '0;
      step();
      chk("drain_valid", 32'(bus.out_valid), 'd0);
      chk("drain_hold_bin", 32'(bus.out_bin), 'b0100);

      // rr_ptr=3, wrap to 0 then 1
      bus.req_valid = 4'b0011;
      lane(0, 4'b1011);
      lane(1, 4'b0001);
      #1;
      chk("wrap_ready0", 32'(bus.req_ready), 'b0001);
      step();
      chk("wrap_id0", 32'(bus.out_id), 'd0);
      chk("wrap_bin0", 32'(bus.out_bin), 'b1101);
      chk("wrap_ready1", 32'(bus.req_ready), 'b0010);
      step();
      chk("wrap_id1", 32'(bus.out_id), 'd1);
      chk("wrap_bin1", 32'(bus.out_bin), 'b0001);
      bus.req_valid = '0;
      step();

      // backpressure: Gray 1000 -> 1111 held 5 cycles
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0001;
      lane(0, 4'b1000);
      step();
      bus.req_valid = 4'b1000;
      lane(3, 4'b0011);
      for (int c = 0; c < 5; c++) begin
         chk("bp_ready", 32'(bus.req_ready), 'b0000);
         chk("bp_valid", 32'(bus.out_valid), 'd1);
         chk("bp_bin", 32'(bus.out_bin), 'b1111);
         chk("bp_id", 32'(bus.out_id), 'd0);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 'b1000);
      step();
      chk("bp_next_valid", 32'(bus.out_valid), 'd1);
      chk("bp_next_id", 32'(bus.out_id), 'd3);
      chk("bp_next_bin", 32'(bus.out_bin), 'b0010);
      bus.req_valid = '0;
      step();

      // round robin, all requesting, no bubbles
      lane(0, 4'b0000);
      lane(1, 4'b0011);
      lane(2, 4'b0101);
      lane(3, 4'b1100);
      bus.req_valid = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         step();
         chk("rr_valid", 32'(bus.out_valid), 'd1);
         chk("rr_id", 32'(bus.out_id), 32'(j % 4));
         chk("rr_bin", 32'(bus.out_bin), rr_bin[j % 4]);
      end

      // reset while FULL and stalled
      bus.out_ready = 1'b0;
      step();
      chk("stall_id", 32'(bus.out_id), 'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.out_valid), 'd0);
      chk("mid_rst_bin", 32'(bus.out_bin), 'd0);
      chk("mid_rst_id", 32'(bus.out_id), 'd0);
      chk("mid_rst_ready", 32'(bus.req_ready), 'b0001);
      bus.out_ready = 1'b1;
      step();
      chk("post_rst_id", 32'(bus.out_id), 'd0);
      chk("post_rst_valid", 32'(bus.out_valid), 'd1);

`ifdef GRAY_CONV_ARB_STATS_EN
      // 65537 handshakes wrap the counter to 1
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_rst", 32'(conv_count), 'd0);
      step();
      chk("cnt_first", 32'(conv_count), 'd0);
      for (int n = 0; n < 65537; n++) begin
         step();
      end
      chk("cnt_wrap", 32'(conv_count), 'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one SIZE-bit Gray-to-binary converter among NREQ requesters using round-robin arbitration with valid/ready handshakes. The winning request's Gray word is converted combinationally and registered into a single-entry output stage tagged with the requester ID. The block sits between several Gray-coded pointer or counter sources and a single downstream consumer of binary values.

Parameters:
- SIZE, 4, Gray/binary word width (>=2)
- NREQ, 4, number of requesters (2..16)
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NREQ

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_gray  input  NREQ*SIZE  packed Gray words; requester k occupies bits [k*SIZE +: SIZE]
- req_ready  output  NREQ  one-hot grant/accept, combinational
- out_valid  output  1  converted result valid
- out_bin  output  SIZE  binary result, Bin[i] = XOR of Gray[SIZE-1:i]
- out_id  output  ID_W  index of the requester that produced out_bin
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_bin=0, out_id=0.
  - Round-robin pointer rr_ptr=0.
  - FSM enters EMPTY.
  - Reset overrides everything, including a pending transfer mid-handshake; the held result is discarded.
- FSM states:
  - EMPTY: output register holds no data.
  - FULL: out_valid=1 and the output register holds a result.
- Load enable: load = (state==EMPTY) || (state==FULL && out_ready).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping from NREQ-1 to 0. The first asserted index is the grant g.
  - req_ready[g] = load & |req_valid. All other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid=0.
  - A transfer occurs on requester k when req_valid[k] & req_ready[k].
- On a transfer, at the next edge:
  - out_bin <= gray2bin(req_gray[g]), out_id <= g, out_valid <= 1, state <= FULL.
  - rr_ptr <= (g==NREQ-1) ? 0 : g+1.
- FSM transitions:
  - EMPTY -> FULL on a transfer. EMPTY stays EMPTY when no req_valid is asserted.
  - FULL with out_ready=1 and a transfer: stays FULL; the register reloads in the same cycle, giving 1 result/cycle throughput.
  - FULL with out_ready=1 and no request: -> EMPTY, out_valid <= 0. out_bin and out_id hold their last values.
  - FULL with out_ready=0: hold all outputs, all req_ready=0, rr_ptr unchanged.
- Latency: 1 cycle from a transfer to out_valid.
- out_bin, out_id and out_valid are stable while out_valid=1 and out_ready=0.
- Fairness: a continuously requesting requester is granted within NREQ transfers.
- rr_ptr changes only on a transfer. With a single active requester, that requester is granted every load cycle.
- Requesters may change req_gray or drop req_valid while not granted; only the value at the transfer edge is used.

Optional Feature:
- Macro: GRAY_CONV_ARB_STATS_EN.
- When defined, adds output port conv_count, 16 bits.
  - Increments by 1 on every output handshake (out_valid & out_ready).
  - Wraps 16'hFFFF -> 0.
  - Reset value 0.
- When undefined, the port and counter do not exist. All other behaviour is identical in both cases.

Test Plan:
- Reset mid-operation: FULL with out_ready=0, assert rst for 1 cycle -> out_valid=0, out_bin=0, out_id=0 next cycle; first grant after reset goes to requester 0 when all request.
- Single requester: req_valid=4'b0100, req_gray[2]=4'b0110, out_ready=1 -> req_ready=4'b0100, next cycle out_valid=1, out_bin=4'b0100, out_id=2.
- Round-robin: all four requesting, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3, one result per cycle, no bubbles.
- Backpressure: out_valid=1 holding Gray 4'b1000 -> out_bin=4'b1111; hold out_ready=0 for 5 cycles -> req_ready=0, outputs stable; raise out_ready -> next pending request loads the same cycle.
- Wrap/skip: rr_ptr=3, req_valid=4'b0011 -> grant requester 0; next grant requester 1; Gray 4'b1011 -> out_bin=4'b1101.
- With GRAY_CONV_ARB_STATS_EN: 65537 output handshakes -> conv_count=1; without the macro, the bench compiles with no conv_count port.
